// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered status flags, sticky overflow/underflow
// and selectable registered-read or first-word-fall-through output.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDRESS_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_LEVEL  = 6,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
  parameter int unsigned FWFT               = 0
) (
  input  logic                     Clock,
  input  logic                     Reset_Enable,
  input  logic                     Flush,
  input  logic                     Write_Enable,
  input  logic [DATA_WIDTH-1:0]    Data_In,
  input  logic                     Read_Enable,
  output logic [DATA_WIDTH-1:0]    Data_Out,
  output logic                     Data_Valid,
  output logic                     Full,
  output logic                     Empty,
  output logic                     Almost_Full,
  output logic                     Almost_Empty,
  output logic [ADDRESS_WIDTH:0]   Fill_Count,
  output logic                     Overflow,
  output logic                     Underflow
);

  localparam int unsigned DATA_DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int unsigned CNT_WIDTH  = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [DATA_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_next_c;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_next_c;
  logic [CNT_WIDTH-1:0]     fill_next_c;
  logic [DATA_WIDTH-1:0]    head_next_c;
  logic                     wr_accept_c;
  logic                     rd_accept_c;

  // Accept decode and next-state arithmetic; Flush overrides both requests.
  always_comb begin
    wr_accept_c   = Write_Enable && !Full  && !Flush;
    rd_accept_c   = Read_Enable  && !Empty && !Flush;
    wr_ptr_next_c = wr_ptr;
    rd_ptr_next_c = rd_ptr;
    fill_next_c   = Fill_Count;

    if (Flush) begin
      wr_ptr_next_c = '0;
      rd_ptr_next_c = '0;
      fill_next_c   = '0;
    end else begin
      if (wr_accept_c) wr_ptr_next_c = wr_ptr + ADDRESS_WIDTH'(1);
      if (rd_accept_c) rd_ptr_next_c = rd_ptr + ADDRESS_WIDTH'(1);
      if (wr_accept_c && !rd_accept_c)      fill_next_c = Fill_Count + CNT_WIDTH'(1);
      else if (rd_accept_c && !wr_accept_c) fill_next_c = Fill_Count - CNT_WIDTH'(1);
    end

    // Head word after this edge; bypass when the incoming write lands on it.
    if (wr_accept_c && (wr_ptr == rd_ptr_next_c)) head_next_c = Data_In;
    else                                          head_next_c = mem[rd_ptr_next_c];
  end

  // Storage is deliberately unreset; reset still blocks a same-cycle write.
  always_ff @(posedge Clock) begin
    if (!Reset_Enable && wr_accept_c) mem[wr_ptr] <= Data_In;
  end

  // Pointers, count and flags registered from the next-state count.
  always_ff @(posedge Clock) begin
    if (Reset_Enable) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Fill_Count   <= '0;
      Full         <= 1'b0;
      Empty        <= 1'b1;
      Almost_Full  <= 1'b0;
      Almost_Empty <= 1'b1;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next_c;
      rd_ptr       <= rd_ptr_next_c;
      Fill_Count   <= fill_next_c;
      Full         <= (fill_next_c == CNT_WIDTH'(DATA_DEPTH));
      Empty        <= (fill_next_c == '0);
      Almost_Full  <= (fill_next_c >= CNT_WIDTH'(ALMOST_FULL_LEVEL));
      Almost_Empty <= (fill_next_c <= CNT_WIDTH'(ALMOST_EMPTY_LEVEL));
      if (Flush) begin
        Overflow  <= 1'b0;
        Underflow <= 1'b0;
      end else begin
        if (Write_Enable && Full) Overflow  <= 1'b1;
        if (Read_Enable && Empty) Underflow <= 1'b1;
      end
    end
  end

  // Output data path: pulse-per-read in registered mode, live head in FWFT.
  always_ff @(posedge Clock) begin
    if (Reset_Enable) begin
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
    end else if (FWFT == 0) begin
      Data_Valid <= rd_accept_c;
      if (rd_accept_c) Data_Out <= mem[rd_ptr];
    end else begin
      Data_Valid <= (fill_next_c != '0);
      if (rd_accept_c || (wr_accept_c && Empty)) Data_Out <= head_next_c;
    end
  end

endmodule
